// File: rtl/ep_arb_n.sv
// N-client round-robin arbiter for the shared TRN transmit path of one channel; chainable via chn_*.
// Optional grant watchdog is built when EP_ARB_WATCHDOG_EN is defined.
module ep_arb_n #(
  parameter  int NCH    = 3,
  parameter  int GNT_TO = 64,
  localparam int CW     = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           chn_trn,
  output logic           chn_drvn,
  output logic           chn_reqep,
  input  logic [NCH-1:0] req_ep,
  input  logic [NCH-1:0] drv_ep,
  output logic [NCH-1:0] my_trn,
  output logic           gnt_to,
  output logic           arb_err,
  output logic [CW-1:0]  err_idx
);

  if (NCH < 2 || NCH > 16) begin : g_bad_nch
    $error("ep_arb_n: NCH must be in 2..16");
  end
  if (GNT_TO < 2) begin : g_bad_gnt_to
    $error("ep_arb_n: GNT_TO must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    REQ_UP,
    GRANT,
    BUSY,
    RELEASE
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  win_q, win_d;
  logic [CW-1:0]  ptr_q, ptr_d;
  logic [NCH-1:0] my_trn_q, my_trn_d;
  logic           chn_reqep_q, chn_reqep_d;
  logic           arb_err_q, arb_err_d;
  logic [CW-1:0]  err_idx_q, err_idx_d;
  logic [NCH-1:0] err_vec;
  logic [CW-1:0]  first_err;

`ifdef EP_ARB_WATCHDOG_EN
  localparam int             WDW     = $clog2(GNT_TO) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(GNT_TO - 1);

  logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
  logic           wd_fire;
  logic           gnt_to_q;
`endif

  // First requesting client at or above ptr, wrapping NCH-1 -> 0.
  function automatic logic [CW-1:0] rr_pick(input logic [NCH-1:0] req,
                                            input logic [CW-1:0]  ptr);
    logic [CW-1:0] pick;
    int            idx;
    pick = ptr;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (req[CW'(idx)]) pick = CW'(idx);
    end
    return pick;
  endfunction

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
`ifdef EP_ARB_WATCHDOG_EN
    wd_fire = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req_ep) state_d = REQ_UP;
      end
      REQ_UP: begin
        if (!(|req_ep)) begin
          state_d = IDLE;
        end else if (chn_trn) begin
          win_d   = rr_pick(req_ep, ptr_q);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (drv_ep[win_q]) begin
          state_d = BUSY;
`ifdef EP_ARB_WATCHDOG_EN
        end else if (wd_cnt_q == WD_LAST) begin
          state_d = RELEASE;
          wd_fire = 1'b1;
`endif
        end else if (!req_ep[win_q]) begin
          state_d = RELEASE;
        end
      end
      BUSY: begin
        // Upstream token loss is ignored here; only the owner ends its transfer.
        if (!drv_ep[win_q]) state_d = RELEASE;
      end
      RELEASE: begin
        ptr_d   = (win_q == LAST) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    my_trn_d = '0;
    if (state_d == GRANT || state_d == BUSY) my_trn_d[win_d] = 1'b1;
    chn_reqep_d = (state_d == REQ_UP) || (state_d == GRANT) || (state_d == BUSY);
  end

  // The releasing owner may still be dropping drv_ep during RELEASE.
  always_comb begin
    err_vec = drv_ep & ~my_trn_q;
    if (state_q == RELEASE) err_vec[win_q] = 1'b0;
    first_err = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (err_vec[CW'(i)]) first_err = CW'(i);
    end
    arb_err_d = arb_err_q | (|err_vec);
    err_idx_d = (!arb_err_q && (|err_vec)) ? first_err : err_idx_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= '0;
      ptr_q       <= '0;
      my_trn_q    <= '0;
      chn_reqep_q <= 1'b0;
      arb_err_q   <= 1'b0;
      err_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      ptr_q       <= ptr_d;
      my_trn_q    <= my_trn_d;
      chn_reqep_q <= chn_reqep_d;
      arb_err_q   <= arb_err_d;
      err_idx_q   <= err_idx_d;
    end
  end

`ifdef EP_ARB_WATCHDOG_EN
  assign wd_cnt_d = (state_q == GRANT && state_d == GRANT) ? wd_cnt_q + 1'b1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      gnt_to_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      gnt_to_q <= wd_fire;
    end
  end

  assign gnt_to = gnt_to_q;
`else
  assign gnt_to = 1'b0;
`endif

  assign chn_drvn  = |drv_ep;
  assign chn_reqep = chn_reqep_q;
  assign my_trn    = my_trn_q;
  assign arb_err   = arb_err_q;
  assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_ep_arb_n.sv
// Directed self-checking bench for ep_arb_n (NCH=3, GNT_TO=8); the watchdog scenario
// is selected by EP_ARB_WATCHDOG_EN, otherwise indefinite grant holding is checked.
module tb_ep_arb_n;
  localparam int NCH = 3;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           chn_trn;
  logic           chn_drvn;
  logic           chn_reqep;
  logic [NCH-1:0] req_ep;
  logic [NCH-1:0] drv_ep;
  logic [NCH-1:0] my_trn;
  logic           gnt_to;
  logic           arb_err;
  logic [CW-1:0]  err_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ep_arb_n #(.NCH(NCH), .GNT_TO(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .chn_trn   (chn_trn),
    .chn_drvn  (chn_drvn),
    .chn_reqep (chn_reqep),
    .req_ep    (req_ep),
    .drv_ep    (drv_ep),
    .my_trn    (my_trn),
    .gnt_to    (gnt_to),
    .arb_err   (arb_err),
    .err_idx   (err_idx)
  );

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic ok);
    int n = 0;
    while (my_trn === '0 && n < 20) begin
      step();
      n++;
    end
    ok = (my_trn !== '0);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_grant: no grant within 20 cycles, my_trn=%b", my_trn);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; chn_trn = 1'b0; req_ep = '0; drv_ep = '0;
    repeat (2) step();
    checks++; if (my_trn !== 3'b000) begin errors++; $display("FAIL reset_my_trn: got %b want 000", my_trn); end
    checks++; if (chn_reqep !== 1'b0) begin errors++; $display("FAIL reset_chn_reqep: got %b want 0", chn_reqep); end
    checks++; if (gnt_to !== 1'b0) begin errors++; $display("FAIL reset_gnt_to: got %b want 0", gnt_to); end
    checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL reset_arb_err: got %b want 0", arb_err); end
    checks++; if (err_idx !== 2'd0) begin errors++; $display("FAIL reset_err_idx: got %0d want 0", err_idx); end
    checks++; if (chn_drvn !== 1'b0) begin errors++; $display("FAIL reset_chn_drvn: got %b want 0", chn_drvn); end
    rst = 1'b0;
    step();
  endtask

  // All three request continuously; each owner drives for 4 cycles.
  task automatic test_round_robin();
    int order[4] = '{0, 1, 2, 0};
    chn_trn = 1'b1;
    req_ep  = 3'b111;
    for (int g = 0; g < 4; g++) begin
      logic           ok;
      int             hi;
      logic [NCH-1:0] oh;
      oh = 3'b001 << order[g];
      wait_grant(ok);
      checks++; if (my_trn !== oh) begin errors++; $display("FAIL rr_order[%0d]: got %b want %b", g, my_trn, oh); end
      drv_ep = oh;
      if (g == 0) begin
        #1;
        checks++; if (chn_drvn !== 1'b1) begin errors++; $display("FAIL rr_chn_drvn: got %b want 1", chn_drvn); end
      end
      hi = 0;
      for (int k = 0; k < 4; k++) begin
        if (my_trn === oh) hi++;
        step();
      end
      drv_ep = '0;
      if (my_trn === oh) hi++;
      step();
      checks++; if (hi !== 5) begin errors++; $display("FAIL rr_hold[%0d]: got %0d cycles want 5", g, hi); end
      checks++; if (my_trn !== 3'b000 || chn_reqep !== 1'b0) begin
        errors++; $display("FAIL rr_release[%0d]: got my_trn=%b chn_reqep=%b want 000/0", g, my_trn, chn_reqep);
      end
    end
    req_ep = '0;
    repeat (2) step();
  endtask

  // Pointer is now 1; client 1 waits for the upstream token.
  task automatic test_chn_gate();
    req_ep = 3'b010; chn_trn = 1'b0;
    step();
    checks++; if (chn_reqep !== 1'b1) begin errors++; $display("FAIL gate_reqep: got %b want 1", chn_reqep); end
    checks++; if (my_trn !== 3'b000) begin errors++; $display("FAIL gate_no_grant: got %b want 000", my_trn); end
    repeat (9) step();
    checks++; if (my_trn !== 3'b000 || chn_reqep !== 1'b1) begin
      errors++; $display("FAIL gate_wait: got my_trn=%b chn_reqep=%b want 000/1", my_trn, chn_reqep);
    end
    chn_trn = 1'b1;
    step();
    checks++; if (my_trn !== 3'b010) begin errors++; $display("FAIL gate_grant: got %b want 010", my_trn); end
    drv_ep = 3'b010; req_ep = '0;
    step();
    drv_ep = '0;
    step();
    checks++; if (my_trn !== 3'b000) begin errors++; $display("FAIL gate_release: got %b want 000", my_trn); end
    step();
  endtask

  // Pointer is now 2; client 2 keeps its token in BUSY while chn_trn is low.
  task automatic test_no_preempt();
    logic ok;
    req_ep = 3'b100; chn_trn = 1'b1;
    wait_grant(ok);
    checks++; if (my_trn !== 3'b100) begin errors++; $display("FAIL np_grant: got %b want 100", my_trn); end
    drv_ep = 3'b100;
    step();
    chn_trn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (my_trn !== 3'b100) begin errors++; $display("FAIL np_hold[%0d]: got %b want 100", k, my_trn); end
      checks++; if (chn_drvn !== 1'b1) begin errors++; $display("FAIL np_drvn[%0d]: got %b want 1", k, chn_drvn); end
    end
    drv_ep = '0;
    #1;
    checks++; if (chn_drvn !== 1'b0) begin errors++; $display("FAIL np_drvn_fall: got %b want 0", chn_drvn); end
    step();
    checks++; if (my_trn !== 3'b000) begin errors++; $display("FAIL np_release: got %b want 000", my_trn); end
    req_ep = '0; chn_trn = 1'b1;
    step();
  endtask

  // Pointer is now 0; client 1 is granted and never drives.
  task automatic test_grant_timeout();
    logic ok;
    int   n;
    logic saw;
    req_ep = 3'b010; chn_trn = 1'b1;
    wait_grant(ok);
    checks++; if (my_trn !== 3'b010) begin errors++; $display("FAIL to_grant: got %b want 010", my_trn); end
`ifdef EP_ARB_WATCHDOG_EN
    n = 0; saw = 1'b0;
    while (my_trn === 3'b010 && n < 20) begin
      if (gnt_to !== 1'b0) saw = 1'b1;
      n++;
      step();
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL to_cycles: got %0d grant cycles want 8", n); end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL to_early_pulse: gnt_to seen during grant"); end
    checks++; if (gnt_to !== 1'b1 || my_trn !== 3'b000) begin
      errors++; $display("FAIL to_pulse: got gnt_to=%b my_trn=%b want 1/000", gnt_to, my_trn);
    end
    req_ep = 3'b011;
    step();
    checks++; if (gnt_to !== 1'b0) begin errors++; $display("FAIL to_single_pulse: got %b want 0", gnt_to); end
`else
    chn_trn = 1'b0;
    n = 0; saw = 1'b0;
    repeat (100) begin
      if (gnt_to !== 1'b0) saw = 1'b1;
      step();
    end
    checks++; if (my_trn !== 3'b010 || chn_reqep !== 1'b1) begin
      errors++; $display("FAIL hold_grant: got my_trn=%b chn_reqep=%b want 010/1", my_trn, chn_reqep);
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL hold_gnt_to: gnt_to seen without watchdog"); end
    req_ep = 3'b001; chn_trn = 1'b1;
    step();
    checks++; if (my_trn !== 3'b000) begin errors++; $display("FAIL hold_withdraw: got %b want 000", my_trn); end
`endif
    wait_grant(ok);
    checks++; if (my_trn !== 3'b001) begin errors++; $display("FAIL to_wrap_grant: got %b want 001", my_trn); end
    req_ep = '0;
    repeat (3) step();
  endtask

  // Pointer is now 1; client 0 is granted while others drive illegally.
  task automatic test_error();
    logic ok;
    req_ep = 3'b001; chn_trn = 1'b1;
    wait_grant(ok);
    checks++; if (my_trn !== 3'b001 || arb_err !== 1'b0) begin
      errors++; $display("FAIL err_setup: got my_trn=%b arb_err=%b want 001/0", my_trn, arb_err);
    end
    drv_ep = 3'b100;
    step();
    checks++; if (arb_err !== 1'b1) begin errors++; $display("FAIL err_flag: got %b want 1", arb_err); end
    checks++; if (err_idx !== 2'd2) begin errors++; $display("FAIL err_idx: got %0d want 2", err_idx); end
    drv_ep = 3'b011;
    step();
    checks++; if (err_idx !== 2'd2) begin errors++; $display("FAIL err_first_kept: got %0d want 2", err_idx); end
    drv_ep = 3'b001; req_ep = '0;
    step();
    drv_ep = '0;
    repeat (2) step();
    checks++; if (arb_err !== 1'b1 || err_idx !== 2'd2) begin
      errors++; $display("FAIL err_sticky: got arb_err=%b err_idx=%0d want 1/2", arb_err, err_idx);
    end
    rst = 1'b1;
    #1;
    checks++; if (arb_err !== 1'b0 || err_idx !== 2'd0) begin
      errors++; $display("FAIL err_rst_clear: got arb_err=%b err_idx=%0d want 0/0", arb_err, err_idx);
    end
    step();
    rst = 1'b0;
    step();
    drv_ep = 3'b110;
    step();
    checks++; if (arb_err !== 1'b1 || err_idx !== 2'd1) begin
      errors++; $display("FAIL err_lowest: got arb_err=%b err_idx=%0d want 1/1", arb_err, err_idx);
    end
    drv_ep = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  // Pointer is 0 after reset; advance it, then reset in the middle of a transfer.
  task automatic test_reset_mid();
    logic ok;
    req_ep = 3'b001; chn_trn = 1'b1;
    wait_grant(ok);
    checks++; if (my_trn !== 3'b001) begin errors++; $display("FAIL mid_first: got %b want 001", my_trn); end
    req_ep = '0;
    repeat (2) step();
    req_ep = 3'b010;
    wait_grant(ok);
    checks++; if (my_trn !== 3'b010) begin errors++; $display("FAIL mid_second: got %b want 010", my_trn); end
    drv_ep = 3'b010;
    step();
    #3;
    rst = 1'b1;
    #1;
    checks++; if (my_trn !== 3'b000 || chn_reqep !== 1'b0) begin
      errors++; $display("FAIL mid_async: got my_trn=%b chn_reqep=%b want 000/0", my_trn, chn_reqep);
    end
    drv_ep = '0; req_ep = '0;
    step();
    rst = 1'b0;
    step();
    req_ep = 3'b111;
    wait_grant(ok);
    checks++; if (my_trn !== 3'b001) begin errors++; $display("FAIL mid_restart: got %b want 001", my_trn); end
    req_ep = '0;
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_chn_gate();
    test_no_preempt();
    test_grant_timeout();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
